// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage
// Instruction-fetch stage of a 5-stage MIPS pipeline. Holds the PC register
// and the IF/ID pipeline register, follows stall and branch redirects from
// later stages, and detects the halt word. After a halt it drains the
// pipeline, then raises a sticky `fin` flag.
//
// Ports:
//   clk           in   clock, all state changes on the rising edge
//   pcclr         in   synchronous active-high reset
//   stall         in   freeze PC and IF/ID
//   branch_taken  in   redirect fetch to branch_target and flush IF/ID
//   branch_target in   redirect address (bits [1:0] are forced to zero)
//   imem_addr     out  instruction-memory address (the PC register)
//   imem_rdata    in   instruction word at imem_addr, same cycle
//   ifid_instr    out  IF/ID instruction word, zero (NOP) when not valid
//   ifid_pc4      out  IF/ID PC+4 of the held instruction
//   ifid_valid    out  IF/ID holds a real instruction
//   fin           out  program finished, sticky until pcclr
//
// DRAIN_CYCLES must be in the range 1..15 because the drain counter is 4 bits.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN    = 32'hFC00_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        pcclr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fin
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    // Redirect targets are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_e      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q,   ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        fin_q,        fin_d;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;   // wraps naturally at 2^32

    // Next-state and next-register computation for PC, IF/ID and drain FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fin_d        = fin_q;

        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d         = align_word(branch_target);
                    ifid_instr_d = 32'h0000_0000;
                    ifid_pc4_d   = 32'h0000_0000;
                    ifid_valid_d = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (imem_rdata == HALT_INSN) begin
                    // The halt word itself is never issued; PC parks on it.
                    ifid_instr_d = 32'h0000_0000;
                    ifid_valid_d = 1'b0;
                    cnt_d        = DRAIN_INIT;
                    state_d      = ST_DRAIN;
                end else begin
                    pc_d         = pc_plus4_s;
                    ifid_instr_d = imem_rdata;
                    ifid_pc4_d   = pc_plus4_s;
                    ifid_valid_d = 1'b1;
                end
            end

            ST_DRAIN: begin
                if (branch_taken) begin
                    // Halt turned out to be on the wrong path: resume fetching.
                    pc_d         = align_word(branch_target);
                    ifid_instr_d = 32'h0000_0000;
                    ifid_pc4_d   = 32'h0000_0000;
                    ifid_valid_d = 1'b0;
                    cnt_d        = 4'd0;
                    state_d      = ST_RUN;
                end else if (stall) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    fin_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                fin_d = 1'b1;
            end

            default: begin
                // Unreachable encoding: fall back to a flushed RUN state.
                state_d      = ST_RUN;
                cnt_d        = 4'd0;
                ifid_instr_d = 32'h0000_0000;
                ifid_pc4_d   = 32'h0000_0000;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset on pcclr.
    always_ff @(posedge clk) begin
        if (pcclr) begin
            state_q      <= ST_RUN;
            cnt_q        <= 4'd0;
            pc_q         <= RESET_PC;
            ifid_instr_q <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            fin_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fin_q        <= fin_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign fin        = fin_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Testbench for mips_fetch_stage: directed scenarios followed by random
// stall/branch/reset traffic, every cycle compared against a behavioural
// model of the fetch stage.
module tb_mips_fetch_stage;

    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam int          DC   = 4;

    logic        clk;
    logic        pcclr;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fin;

    int checks;
    int errors;

    // Instruction memory: 256 words at 0x000..0x3FC, a fixed pattern above.
    logic [31:0] mem [0:255];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a < 32'd1024) return mem[a[9:2]];
        else              return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    mips_fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .HALT_INSN   (HALT),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk          (clk),
        .pcclr        (pcclr),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .fin          (fin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the stage should hold after each edge.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fin;
    int          m_drain_left;   // non-stalled edges still to go before fin; 0 = fetching

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check32({tag, ".pc"},    imem_addr,          m_pc);
        check32({tag, ".instr"}, ifid_instr,         m_instr);
        check32({tag, ".pc4"},   ifid_pc4,           m_pc4);
        check32({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
        check32({tag, ".fin"},   {31'd0, fin},        {31'd0, m_fin});
    endtask

    // Drive one cycle, advance the model by the spec rules, then compare.
    task automatic cycle(input string tag, input logic rst, input logic st,
                         input logic br, input logic [31:0] tgt);
        logic [31:0] w;
        w             = word_at(m_pc);
        pcclr         = rst;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_fin = 1'b0; m_drain_left = 0;
        end else if (m_fin) begin
            // finished: everything ignored
        end else if (br) begin
            m_pc = tgt & ~32'h3; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_drain_left = 0;
        end else if (st) begin
            // frozen
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_fin = 1'b1;
        end else if (w == HALT) begin
            m_instr = 32'h0; m_valid = 1'b0; m_drain_left = DC;
        end else begin
            m_pc = m_pc + 32'd4; m_instr = w; m_pc4 = m_pc;
            m_valid = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pcclr = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_fin = 1'b0; m_drain_left = 0;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'h3F) mem[i][31] = 1'b0;
        end
        mem[0] = 32'h2008_0001;
        mem[1] = 32'h2009_0002;
        mem[2] = 32'h0000_0000;
        mem[4] = HALT;           // 0x10
        mem[5] = HALT;           // 0x14
        mem[100] = HALT;
        mem[200] = HALT;

        // Reset state
        cycle("reset0", 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("reset1", 1'b1, 1'b1, 1'b1, 32'h80);
        check32("reset_pc_const", imem_addr, 32'h0);

        // Sequential fetch
        cycle("fetch0", 1'b0, 1'b0, 1'b0, 32'h0);
        check32("fetch0_instr_const", ifid_instr, 32'h2008_0001);
        check32("fetch0_pc4_const",   ifid_pc4,   32'h4);
        cycle("fetch1", 1'b0, 1'b0, 1'b0, 32'h0);
        check32("fetch1_instr_const", ifid_instr, 32'h2009_0002);
        check32("fetch1_pc4_const",   ifid_pc4,   32'h8);

        // Stall for 3 cycles at pc 0x8, then resume
        for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 1'b1, 1'b0, 32'h0);
        check32("stall_pc_const", imem_addr, 32'h8);
        cycle("resume", 1'b0, 1'b0, 1'b0, 32'h0);
        check32("resume_pc_const", imem_addr, 32'hC);

        // Branch beats stall, target aligned
        cycle("br_stall", 1'b0, 1'b1, 1'b1, 32'h43);
        check32("br_stall_pc_const", imem_addr, 32'h40);

        // Halt at 0x10 with no stalls, then ignored inputs in DONE
        cycle("to_halt10", 1'b0, 1'b0, 1'b1, 32'h10);
        cycle("halt10_det", 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DC; i++) cycle("drain10", 1'b0, 1'b0, 1'b0, 32'h0);
        check32("fin_const", {31'd0, fin}, 32'd1);
        cycle("done_ign0", 1'b0, 1'b1, 1'b1, 32'h200);
        cycle("done_ign1", 1'b0, 1'b0, 1'b1, 32'h300);
        check32("done_pc_const", imem_addr, 32'h10);

        // Halt at 0x14, stall in drain, then branch away
        cycle("rst2", 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("to_halt14", 1'b0, 1'b0, 1'b1, 32'h14);
        cycle("halt14_det", 1'b0, 1'b0, 1'b0, 32'h0);
        cycle("drain14_st", 1'b0, 1'b1, 1'b0, 32'h0);
        cycle("drain14", 1'b0, 1'b0, 1'b0, 32'h0);
        cycle("abort", 1'b0, 1'b0, 1'b1, 32'h100);
        check32("abort_pc_const", imem_addr, 32'h100);
        for (int i = 0; i < DC + 2; i++) cycle("after_abort", 1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap
        cycle("to_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle("wrap", 1'b0, 1'b0, 1'b0, 32'h0);
        check32("wrap_pc_const",  imem_addr, 32'h0);
        check32("wrap_pc4_const", ifid_pc4,  32'h0);

        // Reset while draining
        cycle("to_halt10b", 1'b0, 1'b0, 1'b1, 32'h10);
        cycle("halt10b_det", 1'b0, 1'b0, 1'b0, 32'h0);
        cycle("drain10b", 1'b0, 1'b0, 1'b0, 32'h0);
        cycle("rst_in_drain", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DC + 1; i++) cycle("post_rst", 1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_st, r_br;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 99) < 2);
            r_st  = ($urandom_range(0, 99) < 25);
            r_br  = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0)
                r_tgt = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
            else
                r_tgt = $urandom;
            cycle("rand", r_rst, r_st, r_br, r_tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on simulation time in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register and the IF/ID pipeline register.
- Drives the instruction-memory address and accepts stall and branch redirects from later stages.
- Detects the halt instruction, drains the pipeline, then raises the sticky `fin` flag that the top level and bench wait on.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_INSN, 32'hFC000000, instruction encoding (opcode 6'b111111) that ends the program.
- DRAIN_CYCLES, 4, non-stalled cycles after halt detection before `fin` rises; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- pcclr  input  1  synchronous, active-high reset.
- stall  input  1  from hazard unit; freeze PC and IF/ID.
- branch_taken  input  1  from branch resolution; redirect fetch.
- branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0.
- imem_addr  output  32  instruction-memory address; equals the PC register.
- imem_rdata  input  32  instruction word at `imem_addr`; combinational, same cycle.
- ifid_instr  output  32  IF/ID instruction; 32'h0 (NOP) when invalid.
- ifid_pc4  output  32  IF/ID PC+4 of the held instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- fin  output  1  program finished; sticky until reset.

Behaviour:
- Reset (`pcclr` = 1 at an edge):
  - pc = RESET_PC; ifid_instr = 0; ifid_pc4 = 0; ifid_valid = 0; fin = 0.
  - state = RUN; drain counter = 0.
  - Reset overrides everything, including mid-DRAIN and DONE.
- States: RUN, DRAIN, DONE.
- Priority in RUN and DRAIN: branch_taken > stall > normal operation.
- RUN, normal (no stall, no branch, imem_rdata != HALT_INSN):
  - pc <= pc+4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
  - ifid_instr <= imem_rdata; ifid_pc4 <= pc+4; ifid_valid <= 1.
  - One-cycle latency from imem_addr to IF/ID.
- RUN, branch_taken:
  - pc <= {branch_target[31:2], 2'b00}.
  - IF/ID flushed: ifid_instr = 0, ifid_pc4 = 0, ifid_valid = 0.
  - Applies even if stall = 1 in the same cycle.
- RUN, stall (no branch): pc and all IF/ID outputs hold their values.
- RUN, imem_rdata == HALT_INSN (no stall, no branch):
  - The halt word is not issued; IF/ID is loaded with NOP and ifid_valid = 0.
  - pc holds; state -> DRAIN; counter <= DRAIN_CYCLES.
  - If a stall is present, the halt is simply re-seen on a later cycle.
- DRAIN:
  - pc frozen; IF/ID held at NOP with ifid_valid = 0.
  - Each non-stalled cycle decrements the counter.
  - When the counter == 1 and there is no stall: state -> DONE and fin <= 1.
  - fin therefore rises exactly DRAIN_CYCLES non-stalled edges after the DRAIN-entry edge.
  - Stall in DRAIN: counter holds.
- DRAIN, branch_taken: the halt was wrong-path.
  - Abort the drain: state -> RUN, counter <= 0.
  - pc <= redirect target; IF/ID flushed as in RUN.
- DONE:
  - fin = 1; pc frozen; IF/ID stays NOP with ifid_valid = 0.
  - stall and branch_taken are ignored.
  - Only `pcclr` leaves DONE.
- imem_addr is always the registered pc, never a combinational next-PC.
- `fin` is registered; no combinational path from any input to `fin`.

Test Plan:
- Reset then release, memory words 0x20080001, 0x20090002, 0x00000000 at 0x0, 0x4, 0x8 -> imem_addr steps 0, 4, 8 on successive edges. The cycle after each fetch, IF/ID shows 0x20080001 with pc4 = 4, then 0x20090002 with pc4 = 8; ifid_valid = 1.
- stall held for 3 cycles while pc = 0x8 -> pc stays 0x8 and IF/ID holds its prior value for 3 cycles; the next free cycle resumes with pc = 0xC.
- branch_taken = 1 and stall = 1 in the same cycle, target 0x43 -> pc = 0x40; IF/ID = NOP, ifid_valid = 0, ifid_pc4 = 0.
- HALT_INSN fetched at pc 0x10, DRAIN_CYCLES = 4, no stalls -> pc stays 0x10 and fin rises on the 4th edge after halt detection. Then assert stall and branch_taken -> fin stays 1 and pc stays 0x10.
- Halt detected at pc 0x14, then one stall cycle during DRAIN, then branch_taken to 0x100 -> fin never rises, state returns to RUN, pc = 0x100, fetch continues normally.
- pc preset via branch to 0xFFFFFFFC, one normal cycle -> pc = 0x00000000 and ifid_pc4 = 0x00000000. Separately, assert pcclr while in DRAIN -> all outputs return to reset values on the next edge.
